// File: rtl/orientation_calc_seq.sv
// rtl/orientation_calc_seq.sv - multi-cycle polar-fix displacement heading solver (12 bins of 30 deg)
module orientation_calc_seq #(
   parameter int R_WIDTH     = 8,
   parameter int THETA_WIDTH = 4,
   parameter int MIN_DELTA   = 256
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [R_WIDTH+THETA_WIDTH-1:0] r_theta_original,
   input  logic [R_WIDTH+THETA_WIDTH-1:0] r_theta_final,
   output logic                           busy,
   output logic                           done,
   output logic [3:0]                     orientation,
   output logic                           stationary,
   output logic                           bad_angle
);

   // Cartesian coordinate width (Q8), displacement width, boundary product width
   localparam int XW = R_WIDTH + 10;
   localparam int DW = XW + 1;
   localparam int PW = DW + 9;

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DELTA, S_CMP} state_t;

   state_t                   state;
   logic [R_WIDTH-1:0]       r_o, r_f;
   logic [THETA_WIDTH-1:0]   k_o, k_f;
   logic                     bad_r;
   logic signed [XW-1:0]     x_o, y_o, x_f, y_f;
   logic [DW-1:0]            adx, ady;
   logic                     dx_neg, dy_neg, small_r;
   logic [1:0]               cnt, m;

   logic signed [DW-1:0]     dx_c, dy_c;
   logic [DW-1:0]            adx_c, ady_c;
   logic [DW:0]              sum_c;
   logic [8:0]               sy_c, sx_c;
   logic [PW-1:0]            py_c, px_c;
   logic [1:0]               m_next;
   logic [3:0]               bin_c;

   // Q8 sine of 15*i degrees for i in 0..6; anything else only arises for illegal codes
   function automatic logic [8:0] sin_q8(input int i);
      case (i)
         0:       return 9'd0;
         1:       return 9'd66;
         2:       return 9'd128;
         3:       return 9'd181;
         4:       return 9'd222;
         5:       return 9'd247;
         6:       return 9'd256;
         default: return 9'd0;
      endcase
   endfunction

   // y = r*sin(15k), using sin(180-a) = sin(a) above 90 degrees
   function automatic logic signed [XW-1:0] conv_y(input logic [R_WIDTH-1:0] r,
                                                   input logic [THETA_WIDTH-1:0] k);
      int         kk;
      logic [XW-1:0] mag;
      kk  = int'(k);
      mag = XW'(r) * XW'(sin_q8((kk <= 6) ? kk : 12 - kk));
      return signed'(mag);
   endfunction

   // x = r*cos(15k), negative in the second quadrant
   function automatic logic signed [XW-1:0] conv_x(input logic [R_WIDTH-1:0] r,
                                                   input logic [THETA_WIDTH-1:0] k);
      int         kk;
      logic [XW-1:0] mag;
      kk  = int'(k);
      mag = XW'(r) * XW'(sin_q8((kk <= 6) ? 6 - kk : kk - 6));
      return (kk > 6) ? -signed'(mag) : signed'(mag);
   endfunction

   // displacement, magnitudes and stationary test from the converted fixes
   always_comb begin
      dx_c  = {x_f[XW-1], x_f} - {x_o[XW-1], x_o};
      dy_c  = {y_f[XW-1], y_f} - {y_o[XW-1], y_o};
      adx_c = dx_c[DW-1] ? unsigned'(-dx_c) : unsigned'(dx_c);
      ady_c = dy_c[DW-1] ? unsigned'(-dy_c) : unsigned'(dy_c);
      sum_c = {1'b0, adx_c} + {1'b0, ady_c};
   end

   // one boundary per CMP cycle (15, 45, 75 deg); a tie stays toward the x axis
   always_comb begin
      sy_c = 9'd0;
      sx_c = 9'd0;
      case (cnt)
         2'd0:    begin sy_c = 9'd247; sx_c = 9'd66;  end
         2'd1:    begin sy_c = 9'd181; sx_c = 9'd181; end
         default: begin sy_c = 9'd66;  sx_c = 9'd247; end
      endcase
      py_c   = PW'(ady) * PW'(sy_c);
      px_c   = PW'(adx) * PW'(sx_c);
      m_next = m + ((py_c > px_c) ? 2'd1 : 2'd0);
   end

   // quadrant folding of the boundary count into a 30-degree bin
   always_comb begin
      bin_c = 4'd0;
      case ({dx_neg, dy_neg})
         2'b00:   bin_c = {2'b00, m_next};
         2'b10:   bin_c = 4'd6 - {2'b00, m_next};
         2'b11:   bin_c = 4'd6 + {2'b00, m_next};
         default: bin_c = (m_next == 2'd0) ? 4'd0 : 4'd12 - {2'b00, m_next};
      endcase
   end

   // control FSM with datapath registers and registered results
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         orientation <= 4'd0;
         stationary  <= 1'b0;
         bad_angle   <= 1'b0;
         r_o         <= '0;
         r_f         <= '0;
         k_o         <= '0;
         k_f         <= '0;
         bad_r       <= 1'b0;
         x_o         <= '0;
         y_o         <= '0;
         x_f         <= '0;
         y_f         <= '0;
         adx         <= '0;
         ady         <= '0;
         dx_neg      <= 1'b0;
         dy_neg      <= 1'b0;
         small_r     <= 1'b0;
         cnt         <= 2'd0;
         m           <= 2'd0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  r_o   <= r_theta_original[R_WIDTH-1:0];
                  k_o   <= r_theta_original[R_WIDTH+THETA_WIDTH-1:R_WIDTH];
                  r_f   <= r_theta_final[R_WIDTH-1:0];
                  k_f   <= r_theta_final[R_WIDTH+THETA_WIDTH-1:R_WIDTH];
                  bad_r <= (int'(r_theta_original[R_WIDTH+THETA_WIDTH-1:R_WIDTH]) > 12) ||
                           (int'(r_theta_final[R_WIDTH+THETA_WIDTH-1:R_WIDTH]) > 12);
                  busy  <= 1'b1;
                  state <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               x_o   <= conv_x(r_o, k_o);
               y_o   <= conv_y(r_o, k_o);
               x_f   <= conv_x(r_f, k_f);
               y_f   <= conv_y(r_f, k_f);
               state <= S_DELTA;
            end
            S_DELTA: begin
               adx     <= adx_c;
               ady     <= ady_c;
               dx_neg  <= dx_c[DW-1];
               dy_neg  <= dy_c[DW-1];
               small_r <= sum_c < (DW+1)'(MIN_DELTA);
               cnt     <= 2'd0;
               m       <= 2'd0;
               state   <= S_CMP;
            end
            default: begin
               m   <= m_next;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd2) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_IDLE;
                  if (bad_r) begin
                     orientation <= 4'd0;
                     stationary  <= 1'b0;
                     bad_angle   <= 1'b1;
                  end else if (small_r) begin
                     orientation <= 4'd0;
                     stationary  <= 1'b1;
                     bad_angle   <= 1'b0;
                  end else begin
                     orientation <= bin_c;
                     stationary  <= 1'b0;
                     bad_angle   <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_orientation_calc_seq.sv
// tb/tb_orientation_calc_seq.sv - scoreboard bench for orientation_calc_seq
module tb_orientation_calc_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] r_theta_original;
   logic [11:0] r_theta_final;
   logic        busy, done, stationary, bad_angle;
   logic [3:0]  orientation;

   int total = 0;
   int bad   = 0;
   logic [5:0] sb[$];

   orientation_calc_seq dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .r_theta_original (r_theta_original),
      .r_theta_final    (r_theta_final),
      .busy             (busy),
      .done             (done),
      .orientation      (orientation),
      .stationary       (stationary),
      .bad_angle        (bad_angle)
   );

   always #5 clock = ~clock;

   function automatic logic [11:0] pk(input int th, input int r);
      return {4'(th), 8'(r)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // monitor: every done pulse pops one expected result
   initial begin
      logic [5:0] e;
      forever begin
         @(negedge clock);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
            end else begin
               e = sb.pop_front();
               chk("orientation", orientation, e[5:2]);
               chk("stationary", stationary, e[1]);
               chk("bad_angle", bad_angle, e[0]);
            end
         end
      end
   end

   // one full computation with cycle-accurate busy/done checks
   task automatic run_op(input logic [11:0] o, input logic [11:0] f,
                         input int eo, input bit es, input bit eb, input bit repulse);
      @(posedge clock); #1;
      start = 1'b1;
      r_theta_original = o;
      r_theta_final = f;
      sb.push_back({4'(eo), es, eb});
      for (int c = 1; c <= 5; c++) begin
         @(posedge clock); #1;
         start = repulse && (c == 3);
         if (c == 1 || c == 3) begin
            r_theta_original = pk(6, 20);
            r_theta_final = pk(0, 0);
         end
         @(negedge clock);
         chk("busy_in_flight", busy, 1);
         chk("no_early_done", done, 0);
      end
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      chk("done_cycle6", done, 1);
      chk("busy_cycle6", busy, 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b1;
      r_theta_original = pk(0, 0);
      r_theta_final = pk(2, 20);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_orient", orientation, 0);
         chk("rst_stat", stationary, 0);
         chk("rst_bad", bad_angle, 0);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
      end

      run_op(pk(0, 0),   pk(2, 20),  1, 0, 0, 0);
      run_op(pk(2, 20),  pk(0, 0),   7, 0, 0, 0);
      run_op(pk(0, 10),  pk(6, 10),  5, 0, 0, 0);
      run_op(pk(4, 50),  pk(4, 50),  0, 1, 0, 0);
      run_op(pk(2, 20),  pk(13, 20), 0, 0, 1, 0);
      run_op(pk(6, 20),  pk(0, 0),   9, 0, 0, 0);
      run_op(pk(0, 0),   pk(12, 10), 6, 0, 0, 0);
      run_op(pk(0, 1),   pk(0, 0),   6, 0, 0, 0);
      run_op(pk(15, 5),  pk(3, 7),   0, 0, 1, 0);
      run_op(pk(13, 50), pk(13, 50), 0, 0, 1, 0);
      run_op(pk(0, 0),   pk(2, 20),  1, 0, 0, 1);

      // reset in cycle 4 aborts the computation with no done
      @(posedge clock); #1;
      start = 1'b1;
      r_theta_original = pk(0, 0);
      r_theta_final = pk(2, 20);
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("abort_busy", busy, 0);
      chk("abort_orient", orientation, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("abort_no_done", done, 0);
      end

      // back-to-back: start in cycle 6 of run A begins run B
      @(posedge clock); #1;
      start = 1'b1;
      r_theta_original = pk(0, 0);
      r_theta_final = pk(2, 20);
      sb.push_back({4'd1, 1'b0, 1'b0});
      for (int c = 1; c <= 5; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
         @(negedge clock);
         chk("b2b_busy_a", busy, 1);
      end
      @(posedge clock); #1;
      start = 1'b1;
      r_theta_original = pk(2, 20);
      r_theta_final = pk(0, 0);
      sb.push_back({4'd7, 1'b0, 1'b0});
      @(negedge clock);
      chk("b2b_done_a", done, 1);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
         @(negedge clock);
         chk("b2b_busy_b", busy, 1);
         chk("b2b_no_done_b", done, 0);
      end
      @(posedge clock); #1;
      @(negedge clock);
      chk("b2b_done_b", done, 1);

      repeat (3) @(negedge clock);
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/orientation_calc_seq.md
Name: orientation_calc_seq

Overview:
- Multi-cycle, parametrised orientation solver for the main FPGA tracking path.
- Takes two packed polar fixes of the rover, original and final, as produced by the ultrasound locator.
- Converts both fixes to Cartesian, forms the displacement and quantises its heading into 12 bins of 30°.
- Generalises the angle set to any multiple of 15° over 0..180°, adds a start/busy/done handshake and flags stationary and illegal-angle cases.

Parameters:
- R_WIDTH, 8, width of radius field (unsigned, integer units).
- THETA_WIDTH, 4, width of angle code field; code k means k*15°, legal 0..12.
- MIN_DELTA, 256, stationary threshold on |dx|+|dy| in Q8 units (256 = 1 radius unit).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- r_theta_original  in  R_WIDTH+THETA_WIDTH  r in [R_WIDTH-1:0], theta code in upper bits
- r_theta_final  in  R_WIDTH+THETA_WIDTH  same packing
- busy  out  1  high while a computation is in flight
- done  out  1  one-cycle pulse, results valid
- orientation  out  4  heading bin 0..11; bin b = b*30°, counter-clockwise from +x
- stationary  out  1  displacement below MIN_DELTA
- bad_angle  out  1  either theta code >12

Behaviour:
- Reset: state IDLE; busy, done, stationary and bad_angle = 0; orientation = 0; all internal registers cleared. Reset mid-operation aborts, and no done pulse follows.
- Inputs are latched on the accepted start cycle; later input changes are ignored. A start outside IDLE is ignored, with no queueing.
- Sine table, Q8 unsigned 9 bit:
  - 0° = 0, 15° = 66, 30° = 128, 45° = 181
  - 60° = 222, 75° = 247, 90° = 256
- Conversion for code k:
  - y = r*sin(15k).
  - For k ≤ 6, x = r*sin(90-15k).
  - For k > 6, x = -r*sin(15k-90).
  - x and y are 18-bit signed Q8.
- Displacement: dx = x_f - x_o, dy = y_f - y_o, both 19-bit signed.
- Quadrant from signs, with zero counted as positive:
  - Q1: dx ≥ 0, dy ≥ 0
  - Q2: dx < 0, dy ≥ 0
  - Q3: dx < 0, dy < 0
  - Q4: dx ≥ 0, dy < 0
- Boundary count m (0..3): for each boundary b in {15, 45, 75}, m increments iff |dy|*sin(90-b) > |dx|*sin(b). Products are 28-bit unsigned. A tie does not increment, so it rounds toward the x axis.
- Heading and bin:
  - Q1: heading = 30m
  - Q2: heading = 180-30m
  - Q3: heading = 180+30m
  - Q4: heading = 360-30m, mod 360
  - orientation = heading/30
- Stationary: if |dx|+|dy| < MIN_DELTA, then stationary = 1 and orientation = 0.
- Bad angle: if either code >12, then bad_angle = 1, orientation = 0, stationary = 0. The latency is unchanged.
- FSM: IDLE → CONVERT (1 cycle) → DELTA (1 cycle) → CMP (3 cycles, 2-bit counter, one boundary per cycle) → IDLE.
- Timing:
  - Start is accepted in cycle 0.
  - busy = 1 in cycles 1..5.
  - done = 1 in cycle 6, with the state back in IDLE.
  - A start in cycle 6 is accepted and begins the next computation.
  - orientation, stationary and bad_angle update only with done and hold until the next done.

Test Plan:
- Reset, then idle -> all outputs 0; start asserted while reset is high -> ignored.
- Original r=0 code 0; final r=20 code 2 (x=4440, y=2560) -> m=1, done in cycle 6, orientation=1, stationary=0, bad_angle=0, busy high cycles 1..5.
- Original r=20 code 2; final r=0 -> dx=-4440, dy=-2560, Q3 -> orientation=7.
- Original r=10 code 0; final r=10 code 6 (dx=-2560, dy=2560) -> tie at 45° does not count, m=1 -> orientation=5 (150°).
- Identical inputs r=50 code 4 -> stationary=1, orientation=0. Theta code 13 on final -> bad_angle=1, done still at cycle 6.
- Start re-pulsed in cycle 3 -> ignored. Reset in cycle 4 -> busy=0 next cycle, no done. New start in cycle 6 of a prior run -> accepted back-to-back.
